rca_result_writeback: RTL

- Result collector at the output end of the RCA grid.
- After an accelerated instruction issues, it pops one result from each enabled output IO unit FIFO and writes it to the register file through a single valid/ack writeback port.
- When all results are written, it flushes the IO unit FIFOs and signals done.
- It drives the grid's io_fifo_pop and io_units_rst controls.

---
 rtl/rca_result_writeback_if.sv | 40 ++++
 rtl/rca_result_writeback.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rca_result_writeback_if.sv
// Grid-side and register-file-side signals of the RCA result writeback block.
// master: the writeback collector. slave: the grid IO units plus the register file.
interface rca_result_writeback_if #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NUM_IO_UNITS = 4
);
    // Grid output IO unit FIFOs
    logic [NUM_IO_UNITS-1:0][XLEN-1:0] io_unit_data_out;
    logic [NUM_IO_UNITS-1:0]           io_unit_data_valid_out;
    logic [NUM_IO_UNITS-1:0]           io_fifo_pop;
    logic                              io_units_rst;

    // Register file writeback port
    logic                              wb_valid;
    logic [4:0]                        wb_rd;
    logic [XLEN-1:0]                   wb_data;
    logic                              wb_ack;

    modport master (
        input  io_unit_data_out,
        input  io_unit_data_valid_out,
        output io_fifo_pop,
        output io_units_rst,
        output wb_valid,
        output wb_rd,
        output wb_data,
        input  wb_ack
    );

    modport slave (
        output io_unit_data_out,
        output io_unit_data_valid_out,
        input  io_fifo_pop,
        input  io_units_rst,
        input  wb_valid,
        input  wb_rd,
        input  wb_data,
        output wb_ack
    );
endinterface

// File: rtl/rca_result_writeback.sv
// RCA result collector: after an accelerated instruction issues, drains one
// result from each enabled output IO unit FIFO (lowest ready index first),
// writes it to the register file over a valid/ack port, then flushes the
// IO unit FIFOs and pulses done. Writes to x0 are popped but not written.
module rca_result_writeback #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned NUM_IO_UNITS   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NUM_IO_UNITS-1:0]      wb_unit_mask,
    input  logic [NUM_IO_UNITS-1:0][4:0] rd_addrs,
    input  logic                         abort,
    rca_result_writeback_if.master       bus,
    output logic                         busy,
    output logic                         done,
    output logic                         timeout_err
);

    localparam int unsigned IDX_W = (NUM_IO_UNITS > 1) ? $clog2(NUM_IO_UNITS) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WB,
        FLUSH
    } state_t;

    state_t                         state, state_nx;
    logic [NUM_IO_UNITS-1:0]        pending, pending_nx;
    logic [NUM_IO_UNITS-1:0][4:0]   rd_q, rd_nx;
    logic [CNT_W-1:0]               cnt, cnt_nx;

    logic                           wb_valid_q, wb_valid_nx;
    logic [4:0]                     wb_rd_q, wb_rd_nx;
    logic [XLEN-1:0]                wb_data_q, wb_data_nx;
    logic                           io_units_rst_q;
    logic                           timeout_hit;

    logic [NUM_IO_UNITS-1:0]        cand;
    logic                           sel_any;
    logic [IDX_W-1:0]               sel_idx;
    logic                           take;
    logic [NUM_IO_UNITS-1:0]        pop;

    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.io_units_rst = io_units_rst_q;
    assign bus.io_fifo_pop  = pop;

    // Lowest-index pending unit whose FIFO currently holds data
    always_comb begin
        cand    = pending & bus.io_unit_data_valid_out;
        sel_any = 1'b0;
        sel_idx = '0;
        for (int unsigned i = 0; i < NUM_IO_UNITS; i++) begin
            if (cand[i] && !sel_any) begin
                sel_any = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    // Pop is the only combinational output; abort and reset suppress it
    always_comb begin
        take = (state == SCAN) && !abort && !rst && sel_any;
        pop  = '0;
        if (take) begin
            pop[sel_idx] = 1'b1;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx    = state;
        pending_nx  = pending;
        rd_nx       = rd_q;
        cnt_nx      = cnt;
        wb_valid_nx = wb_valid_q;
        wb_rd_nx    = wb_rd_q;
        wb_data_nx  = wb_data_q;
        timeout_hit = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    pending_nx = wb_unit_mask;
                    rd_nx      = rd_addrs;
                    cnt_nx     = '0;
                    state_nx   = (|wb_unit_mask) ? SCAN : FLUSH;
                end
            end

            SCAN: begin
                if (abort) begin
                    state_nx = FLUSH;
                end else if (sel_any) begin
                    pending_nx[sel_idx] = 1'b0;
                    wb_data_nx          = bus.io_unit_data_out[sel_idx];
                    wb_rd_nx            = rd_q[sel_idx];
                    cnt_nx              = '0;
                    if (rd_q[sel_idx] != 5'd0) begin
                        wb_valid_nx = 1'b1;
                        state_nx    = WB;
                    end else begin
                        state_nx = (|pending_nx) ? SCAN : FLUSH;
                    end
                end else if (cnt == CNT_LIMIT) begin
                    timeout_hit = 1'b1;
                    state_nx    = FLUSH;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            WB: begin
                if (abort) begin
                    wb_valid_nx = 1'b0;
                    state_nx    = FLUSH;
                end else if (bus.wb_ack) begin
                    wb_valid_nx = 1'b0;
                    state_nx    = (|pending) ? SCAN : FLUSH;
                end
            end

            FLUSH: begin
                pending_nx = '0;
                state_nx   = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and registered outputs; done/flush/timeout pulse during FLUSH
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pending        <= '0;
            rd_q           <= '0;
            cnt            <= '0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            io_units_rst_q <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            state          <= state_nx;
            pending        <= pending_nx;
            rd_q           <= rd_nx;
            cnt            <= cnt_nx;
            wb_valid_q     <= wb_valid_nx;
            wb_rd_q        <= wb_rd_nx;
            wb_data_q      <= wb_data_nx;
            io_units_rst_q <= (state_nx == FLUSH);
            busy           <= (state_nx != IDLE);
            done           <= (state_nx == FLUSH);
            timeout_err    <= timeout_hit;
        end
    end

endmodule
